edge_bus_sched: RTL and testbench
=================================

EDGE_BUS_SCHED -- requirements
Module: edge_bus_sched

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 428, meaning input image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 428, meaning input image height in pixels (>=3).
REQ-003 SHALL have parameter RD_BASE, default 1, meaning word address of input pixel (0,0).
REQ-004 SHALL have parameter WR_BASE, default 183184, meaning word address of output pixel 0.
REQ-005 SHALL have ports as below; single clock; reset asynchronous, active-low.
  clk  in  1  system clock, all logic on rising edge
  n_rst  in  1  asynchronous active-low reset
  start  in  1  begin frame when IDLE or DONE
  stop  in  1  synchronous abort
  done  out  1  frame complete, held until start or stop
  haddr  out  32  bus word address
  hwrite  out  1  1 = write transfer, 0 = read transfer
  hwdata  out  32  write data {res_data,8'h00}
  hrdata  in  32  read data, pixel in [31:8]
  hready  in  1  current transfer completes at this edge
  pix_valid  out  1  one-cycle pulse, pix_data valid
  pix_data  out  24  captured hrdata[31:8]
  pix_col_first  out  1  pix_data belongs to column 0 of current output row
  res_valid  in  1  datapath result offered
  res_data  in  24  datapath result pixel
  res_ready  out  1  result FIFO not full

Function
REQ-006 SHALL implement states IDLE, RD, WR, DONE.
REQ-007 SHALL sequence reads per output row r=0..IMG_HEIGHT-3, per column c=0..IMG_WIDTH-1, rows r, r+1, r+2; address RD_BASE+row*IMG_WIDTH+c.
REQ-008 SHALL issue (IMG_HEIGHT-2)*IMG_WIDTH*3 reads and (IMG_HEIGHT-2)*(IMG_WIDTH-2) writes per frame, writes to WR_BASE+k, k incrementing from 0.
REQ-009 SHALL hold haddr, hwrite, hwdata stable from presentation until hready sampled high; the next transfer's address SHALL appear on the following cycle (registered).
REQ-010 SHALL, on read completion (hready high in RD), assert pix_valid with pix_data=hrdata[31:8] on the next cycle (latency 1).
REQ-011 SHALL buffer results in a 2-entry FIFO; push when res_valid && res_ready; res_ready = FIFO not full.
REQ-012 SHALL, at each transfer boundary, choose WR if FIFO non-empty, else RD if reads remain, else stay idle on bus (hwrite=0, haddr unchanged).
REQ-013 SHALL pop the FIFO on write completion; a simultaneous push and pop on a full FIFO SHALL be accepted with no loss.
REQ-014 SHALL enter DONE, assert done, hwrite=0, on completion of the final write; start in DONE restarts the frame with counters cleared.
REQ-015 SHALL treat stop as priority over all events: next cycle IDLE, hwrite=0, FIFO flushed, counters cleared, done=0, in-flight transfer abandoned.
REQ-016 SHALL ignore start while in RD or WR.
REQ-017 SHALL ignore hready in IDLE and DONE.

Reset
REQ-018 SHALL on n_rst low immediately force: state IDLE, haddr=0, hwrite=0, hwdata=0, done=0, pix_valid=0, pix_data=0, pix_col_first=0, res_ready=0, FIFO empty, all counters 0.
REQ-019 SHALL assert res_ready=1 from the first clock after n_rst deasserts.

Configuration
REQ-020 SHALL, with EDGE_BUS_PERF_CNT_EN defined, add output stall_cnt[31:0] counting cycles in RD or WR with hready low, cleared by reset, start and stop, saturating at 0xFFFFFFFF.
REQ-021 SHALL, without EDGE_BUS_PERF_CNT_EN, omit port stall_cnt and its logic; all other behaviour identical.

Verification
REQ-022 W=H=4, hready always 1, res_valid pulsed per 3rd pix_valid after column 2 -> 24 reads at addresses 1,5,9,2,6,10,...; 4 writes to 16..19; done high.
REQ-023 hready low for 3 cycles during read at address 5 -> haddr held 5 for 4 cycles, single pix_valid, stall_cnt=3 (macro defined).
REQ-024 res_valid held high, hready low -> FIFO fills, res_ready=0 after 2 pushes; on next boundary WR chosen before pending read.
REQ-025 stop asserted mid-WR -> next cycle IDLE, hwrite=0, res_ready=1, done=0; subsequent start reads from address RD_BASE.
REQ-026 n_rst asserted mid-frame -> all outputs at REQ-018 values without clock edge; start afterwards gives full frame identical to REQ-022.

Source files
------------

// File: rtl/edge_bus_sched.sv
// Bus scheduler for a 3x3 edge filter: streams 3-row column reads and writes results from a 2-entry FIFO.
// Optional stall counter port stall_cnt is built when EDGE_BUS_PERF_CNT_EN is defined.
module edge_bus_sched #(
  parameter int IMG_WIDTH  = 428,
  parameter int IMG_HEIGHT = 428,
  parameter int RD_BASE    = 1,
  parameter int WR_BASE    = 183184
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        stop,
  output logic        done,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        pix_col_first,
  input  logic        res_valid,
  input  logic [23:0] res_data,
  output logic        res_ready
`ifdef EDGE_BUS_PERF_CNT_EN
  ,output logic [31:0] stall_cnt
`endif
);

  localparam int NWR = (IMG_HEIGHT - 2) * (IMG_WIDTH - 2);
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int WW  = $clog2(NWR + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_END   = RW'(IMG_HEIGHT - 2);
  localparam logic [WW-1:0] WR_LAST   = WW'(NWR - 1);
  localparam logic [WW-1:0] WR_END    = WW'(NWR);
  localparam logic [31:0]   IMG_W32   = 32'(IMG_WIDTH);
  localparam logic [31:0]   RD_BASE32 = 32'(RD_BASE);
  localparam logic [31:0]   WR_BASE32 = 32'(WR_BASE);

  // BUS_IDLE: frame running but nothing to transfer (reads exhausted, FIFO empty).
  typedef enum logic [2:0] {IDLE, RD, WR, BUS_IDLE, DONE} state_t;

  state_t        state, state_d;
  logic [31:0]   haddr_d, hwdata_d;
  logic          hwrite_d;
  logic [RW-1:0] row, row_d, c_row;
  logic [CW-1:0] col, col_d, c_col;
  logic [1:0]    k, k_d, c_k;
  logic [WW-1:0] wr_cnt, wr_cnt_d, c_wr;
  logic          rd_first, rd_first_d;
  logic [23:0]   mem [2];
  logic          wp, rp, head;
  logic [1:0]    cnt, c_avail;
  logic          rdy_en, choose, pop, push, flush, clr, rd_done;
  logic          unused_lsb;

  assign unused_lsb = ^hrdata[7:0];
  assign done       = (state == DONE);
  assign res_ready  = rdy_en && ((cnt != 2'd2) || pop);
  assign push       = res_valid && res_ready;
  assign rd_done    = (state == RD) && hready && !stop;

  always_comb begin
    state_d    = state;
    haddr_d    = haddr;
    hwrite_d   = hwrite;
    hwdata_d   = hwdata;
    rd_first_d = rd_first;
    c_row      = row;
    c_col      = col;
    c_k        = k;
    c_wr       = wr_cnt;
    c_avail    = cnt;
    head       = rp;
    choose     = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        choose  = 1'b1;
        flush   = 1'b1;
        clr     = 1'b1;
        c_row   = '0;
        c_col   = '0;
        c_k     = '0;
        c_wr    = '0;
        c_avail = '0;
      end
      RD: if (hready) choose = 1'b1;
      WR: if (hready) begin
        pop     = 1'b1;
        c_wr    = wr_cnt + WW'(1);
        c_avail = cnt - 2'd1;
        head    = ~rp;
        if (wr_cnt == WR_LAST) begin
          state_d  = DONE;
          hwrite_d = 1'b0;
        end else begin
          choose = 1'b1;
        end
      end
      BUS_IDLE: choose = 1'b1;
      default:  state_d = IDLE;
    endcase
    row_d    = c_row;
    col_d    = c_col;
    k_d      = c_k;
    wr_cnt_d = c_wr;
    // Pending results always go out before the next read so the FIFO never starves the datapath.
    if (choose) begin
      if (c_avail != 2'd0 && c_wr != WR_END) begin
        state_d  = WR;
        hwrite_d = 1'b1;
        haddr_d  = WR_BASE32 + 32'(c_wr);
        hwdata_d = {mem[head], 8'h00};
      end else if (c_row != ROW_END) begin
        state_d    = RD;
        hwrite_d   = 1'b0;
        haddr_d    = RD_BASE32 + (32'(c_row) + 32'(c_k)) * IMG_W32 + 32'(c_col);
        rd_first_d = (c_col == '0);
        if (c_k == 2'd2) begin
          k_d = 2'd0;
          if (c_col == COL_LAST) begin
            col_d = '0;
            row_d = c_row + RW'(1);
          end else begin
            col_d = c_col + CW'(1);
          end
        end else begin
          k_d = c_k + 2'd1;
        end
      end else begin
        state_d  = BUS_IDLE;
        hwrite_d = 1'b0;
      end
    end
    if (stop) begin
      state_d  = IDLE;
      hwrite_d = 1'b0;
      flush    = 1'b1;
      clr      = 1'b1;
      pop      = 1'b0;
      row_d    = '0;
      col_d    = '0;
      k_d      = '0;
      wr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hwdata   <= '0;
      row      <= '0;
      col      <= '0;
      k        <= '0;
      wr_cnt   <= '0;
      rd_first <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      state    <= state_d;
      haddr    <= haddr_d;
      hwrite   <= hwrite_d;
      hwdata   <= hwdata_d;
      row      <= row_d;
      col      <= col_d;
      k        <= k_d;
      wr_cnt   <= wr_cnt_d;
      rd_first <= rd_first_d;
      rdy_en   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= res_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pix_col_first <= 1'b0;
    end else begin
      pix_valid <= rd_done;
      if (rd_done) begin
        pix_data      <= hrdata[31:8];
        pix_col_first <= rd_first;
      end
    end
  end

`ifdef EDGE_BUS_PERF_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                      stall_cnt <= '0;
    else if (clr)                                    stall_cnt <= '0;
    else if ((state == RD || state == WR) && !hready && stall_cnt != '1)
                                                     stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_edge_bus_sched.sv
// Randomized self-checking bench for edge_bus_sched on a 4x4 image; reference derives
// read order, write order and bus hand-over rules from plain arithmetic and queues.
module tb_edge_bus_sched;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int RB  = 1;
  localparam int WB  = 16;
  localparam int NRD = (H - 2) * W * 3;
  localparam int NWR = (H - 2) * (W - 2);

  logic        clk = 1'b0;
  logic        n_rst, start, stop, hready, res_valid;
  logic [31:0] hrdata;
  logic [23:0] res_data;
  logic        done, hwrite, pix_valid, pix_col_first, res_ready;
  logic [31:0] haddr, hwdata;
  logic [23:0] pix_data;
`ifdef EDGE_BUS_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  edge_bus_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .RD_BASE(RB), .WR_BASE(WB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .done(done),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_col_first(pix_col_first),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
`ifdef EDGE_BUS_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5600;
  endfunction

  // j-th read of a frame: output row j/(3W), column (j/3)%W, row offset j%3.
  function automatic int exp_rd_addr(input int j);
    return RB + ((j / (3 * W)) + (j % 3)) * W + ((j / 3) % W);
  endfunction

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if ({done, haddr, hwrite, hwdata, pix_valid, pix_data, pix_col_first, res_ready} !== '0) begin
      n_err++;
      $display("FAIL %s: outputs got done=%b haddr=%0d hwrite=%b hwdata=%h pv=%b pd=%h pcf=%b rr=%b, want all 0",
               tag, done, haddr, hwrite, hwdata, pix_valid, pix_data, pix_col_first, res_ready);
    end
`ifdef EDGE_BUS_PERF_CNT_EN
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL %s stall_cnt: got %0d want 0", tag, stall_cnt); end
`endif
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 0; stop = 0; hready = 0; res_valid = 0; hrdata = '0; res_data = '0;
    #3;
    check_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    #2 n_rst = 1'b1;
    #1;
    n_cmp++;
    if (res_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy_pre: got %b want 0", res_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (res_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy_post: got %b want 1", res_ready); end
  endtask

  task automatic run_frame(input string tag, input int rdy_pct, input int rv_pct, input int stall_addr,
                           input int stall_len, input bit poke_start, input int abort_after);
    int rd_idx = 0, wr_idx = 0, pix_cnt = 0, stalls = 0, occ = 0, stall_left = stall_len;
    logic [23:0] acc[$];
    logic [23:0] gen[$];
    bit pend_pix = 0, pend_first = 0, hold = 0, must_wr = 0, fin = 0, aborted = 0;
    bit active, complete, push;
    logic [23:0] pend_data;
    logic [31:0] h_addr, h_wdata, tmpw;
    logic h_wr;
    @(negedge clk);
    start = 1; stop = 0; res_valid = 0; hready = 1'($urandom_range(1));
    @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 0;
      if (abort_after != 0 && cyc == abort_after) begin aborted = 1; break; end
      n_cmp++;
      if (pix_valid !== pend_pix) begin
        n_err++; $display("FAIL %s pix_valid cyc %0d: got %b want %b", tag, cyc, pix_valid, pend_pix);
      end
      if (pend_pix && pix_valid) begin
        n_cmp++;
        if ({pix_data, pix_col_first} !== {pend_data, pend_first}) begin
          n_err++; $display("FAIL %s pix_data: got %h/%b want %h/%b", tag, pix_data, pix_col_first, pend_data, pend_first);
        end
      end
      if (pix_valid) begin
        pix_cnt++;
        if (pix_cnt % 3 == 0 && ((pix_cnt - 1) / 3) % W >= 2) gen.push_back(24'($urandom));
      end
      if (hold) begin
        n_cmp++;
        if ({haddr, hwrite, hwdata} !== {h_addr, h_wr, h_wdata}) begin
          n_err++; $display("FAIL %s hold: got %0d/%b/%h want %0d/%b/%h", tag, haddr, hwrite, hwdata, h_addr, h_wr, h_wdata);
        end
      end
      if (must_wr) begin
        n_cmp++;
        if (hwrite !== 1'b1) begin n_err++; $display("FAIL %s wr_priority: hwrite got %b want 1", tag, hwrite); end
      end
      if (done) begin
        fin = 1;
        n_cmp++;
        if (rd_idx != NRD || wr_idx != NWR || pix_cnt != NRD || hwrite !== 1'b0) begin
          n_err++; $display("FAIL %s done_counts: got rd=%0d wr=%0d pix=%0d hwrite=%b want %0d/%0d/%0d/0",
                            tag, rd_idx, wr_idx, pix_cnt, hwrite, NRD, NWR, NRD);
        end
        break;
      end
      active = hwrite || (rd_idx < NRD);
      if (active && !hold) begin
        n_cmp++;
        if (!hwrite) begin
          if (haddr !== 32'(exp_rd_addr(rd_idx))) begin
            n_err++; $display("FAIL %s rd_addr[%0d]: got %0d want %0d", tag, rd_idx, haddr, exp_rd_addr(rd_idx));
          end
        end else if (wr_idx < acc.size()) begin
          if ({haddr, hwdata} !== {32'(WB + wr_idx), acc[wr_idx], 8'h00}) begin
            n_err++; $display("FAIL %s wr[%0d]: got %0d/%h want %0d/%h", tag, wr_idx, haddr, hwdata, WB + wr_idx, {acc[wr_idx], 8'h00});
          end
        end else begin
          n_err++; $display("FAIL %s unexpected_write: got addr %0d with %0d results accepted", tag, haddr, acc.size());
        end
      end
      hready = ($urandom_range(99) < rdy_pct);
      if (active && !hwrite && haddr == 32'(stall_addr) && stall_left > 0) begin
        hready = 0; stall_left--;
      end
      hrdata    = mem_word(haddr);
      res_valid = (gen.size() > 0) && ($urandom_range(99) < rv_pct);
      res_data  = (gen.size() > 0) ? gen[0] : 24'($urandom);
      if (poke_start) start = ($urandom_range(7) == 0);
      #1;
      push = res_valid && res_ready;
      if (push) acc.push_back(gen.pop_front());
      complete = active && hready;
      if (active && !hready) stalls++;
      pend_pix = complete && !hwrite;
      must_wr  = 0;
      if (complete) begin
        occ = acc.size() - (push ? 1 : 0) - wr_idx;
        if (hwrite) begin
          occ--; wr_idx++;
        end else begin
          tmpw = mem_word(haddr);
          pend_data  = tmpw[31:8];
          pend_first = ((rd_idx / 3) % W) == 0;
          rd_idx++;
        end
        must_wr = (occ > 0) && (wr_idx < NWR);
      end
      hold = active && !hready;
      h_addr = haddr; h_wr = hwrite; h_wdata = hwdata;
      @(posedge clk);
    end
    if (!fin && !aborted) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: got rd=%0d wr=%0d without done, want done", tag, rd_idx, wr_idx);
    end
`ifdef EDGE_BUS_PERF_CNT_EN
    if (fin) begin
      n_cmp++;
      if (stall_cnt !== 32'(stalls)) begin n_err++; $display("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, stalls); end
    end
`endif
    start = 0; res_valid = 0; hready = 0;
  endtask

  task automatic test_nominal;
    run_frame("nominal", 100, 100, -1, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_held: got %b want 1", done); end
    run_frame("b2b_rand", 70, 60, -1, 0, 1, 0);
    run_frame("b2b_rand2", 40, 30, -1, 0, 1, 0);
  endtask

  task automatic test_stall;
    run_frame("stall5", 100, 100, 5, 3, 0, 0);
  endtask

  task automatic test_fifo_full_stop;
    logic [23:0] a, b;
    logic [31:0] keep, tmpw;
    a = 24'($urandom); b = 24'($urandom);
    @(negedge clk); start = 1; hready = 1; res_valid = 0;
    @(posedge clk);
    @(negedge clk); start = 0;
    n_cmp++;
    if ({haddr, hwrite} !== {32'(RB), 1'b0}) begin n_err++; $display("FAIL fifo_first_rd: got %0d/%b want %0d/0", haddr, hwrite, RB); end
    hready = 0; res_valid = 1; res_data = a; hrdata = mem_word(haddr);
    #1; n_cmp++;
    if (res_ready !== 1'b1) begin n_err++; $display("FAIL fifo_rdy0: got %b want 1", res_ready); end
    @(posedge clk);
    @(negedge clk); res_data = b;
    #1; n_cmp++;
    if (res_ready !== 1'b1) begin n_err++; $display("FAIL fifo_rdy1: got %b want 1", res_ready); end
    @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if ({res_ready, haddr} !== {1'b0, 32'(RB)}) begin n_err++; $display("FAIL fifo_full: got rdy=%b addr=%0d want 0/%0d", res_ready, haddr, RB); end
    res_valid = 0; hready = 1;
    @(posedge clk);
    @(negedge clk);
    tmpw = mem_word(32'(RB));
    n_cmp++;
    if ({hwrite, haddr, hwdata} !== {1'b1, 32'(WB), a, 8'h00}) begin
      n_err++; $display("FAIL fifo_wr_first: got %b/%0d/%h want 1/%0d/%h", hwrite, haddr, hwdata, WB, {a, 8'h00});
    end
    n_cmp++;
    if ({pix_valid, pix_data} !== {1'b1, tmpw[31:8]}) begin
      n_err++; $display("FAIL fifo_pix: got %b/%h want 1/%h", pix_valid, pix_data, tmpw[31:8]);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({hwrite, haddr, hwdata} !== {1'b1, 32'(WB + 1), b, 8'h00}) begin
      n_err++; $display("FAIL fifo_wr_second: got %b/%0d/%h want 1/%0d/%h", hwrite, haddr, hwdata, WB + 1, {b, 8'h00});
    end
    stop = 1; hready = 0;
    @(posedge clk);
    @(negedge clk); stop = 0; keep = haddr;
    n_cmp++;
    if ({hwrite, res_ready, done} !== 3'b010) begin
      n_err++; $display("FAIL stop: got hwrite=%b rdy=%b done=%b want 0/1/0", hwrite, res_ready, done);
    end
    hready = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pix_valid, hwrite, haddr} !== {2'b00, keep}) begin
      n_err++; $display("FAIL idle_ignores_hready: got pv=%b hw=%b addr=%0d want 0/0/%0d", pix_valid, hwrite, haddr, keep);
    end
`ifdef EDGE_BUS_PERF_CNT_EN
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL stop_stall_clr: got %0d want 0", stall_cnt); end
`endif
    hready = 0;
    run_frame("after_stop", 100, 100, -1, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    run_frame("abort", 80, 80, -1, 0, 0, 15);
    #2 n_rst = 1'b0;
    #1 check_reset_vals("reset_mid");
    @(negedge clk); n_rst = 1'b1;
    run_frame("after_reset", 100, 100, -1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_stall();
    test_fifo_full_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
